// File: rtl/cntr_cmd_seq.sv
// cntr_cmd_seq: FIFO-buffered command sequencer emitting registered ld/inc/data_in strobes; optional exp_q shadow under CNTR_SEQ_SHADOW_EN
module cntr_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             ld,
  output logic             inc,
  output logic [WIDTH-1:0] data_in,
`ifdef CNTR_SEQ_SHADOW_EN
  output logic [WIDTH-1:0] exp_q,
`endif
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, EXEC, BURST} state_t;
  state_t state;
  logic [1:0] mem_op [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [1:0] op;
  logic [WIDTH-1:0] arg, rem;
  logic empty, push, pop, long_burst;
  assign empty = cnt == '0;
  assign cmd_ready = cnt != (AW+1)'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign long_burst = op == 2'b11 && arg > WIDTH'(1);
  assign pop = !empty && (state == IDLE || (state == EXEC && !long_burst) || (state == BURST && rem == WIDTH'(1)));
  assign busy = state != IDLE || !empty;
  // command storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wp] <= cmd_op;
      mem_data[wp] <= cmd_data;
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // sequencer: strobes lag the state by one edge; bursts chain into the next command without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      arg <= '0;
      rem <= '0;
      ld <= 1'b0;
      inc <= 1'b0;
      data_in <= '0;
    end else begin
      ld <= state == EXEC && op == 2'b01;
      inc <= (state == EXEC && (op == 2'b10 || (op == 2'b11 && arg != '0))) || state == BURST;
      if (state == EXEC && op == 2'b01) data_in <= arg;
      if (state == BURST) rem <= rem - 1'b1;
      if (state == EXEC && long_burst) begin
        state <= BURST;
        rem <= arg - 1'b1;
      end else if (pop) begin
        state <= EXEC;
        op <= mem_op[rp];
        arg <= mem_data[rp];
      end else if (state != BURST || rem == WIDTH'(1)) state <= IDLE;
    end
  end
`ifdef CNTR_SEQ_SHADOW_EN
  // shadow of the downstream counter, fed by the same strobes it samples
  always_ff @(posedge clk) begin
    if (rst) exp_q <= '0;
    else if (ld) exp_q <= data_in;
    else if (inc) exp_q <= exp_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_cntr_cmd_seq.sv
// tb_cntr_cmd_seq: scoreboard bench for cntr_cmd_seq; define CNTR_SEQ_SHADOW_EN to also check exp_q
module tb_cntr_cmd_seq;
  typedef struct {
    logic       ld;
    logic [7:0] d;
    int         gap;
  } ent_t;
  logic clk, rst, cmd_valid, cmd_ready, ld, inc, busy;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, data_in;
`ifdef CNTR_SEQ_SHADOW_EN
  logic [7:0] exp_q;
`endif
  ent_t q[$];
  ent_t e;
  int vecs, errs, cyc, prev_cyc, ld_cyc, idle_gap, a;
  logic [7:0] mdl, last_d;
  cntr_cmd_seq #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .ld(ld),
    .inc(inc),
    .data_in(data_in),
`ifdef CNTR_SEQ_SHADOW_EN
    .exp_q(exp_q),
`endif
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // monitor: every strobe cycle pops one expected entry
  always @(negedge clk) begin
    if (!rst) begin
`ifdef CNTR_SEQ_SHADOW_EN
      chk("exp_q", exp_q, mdl);
`endif
      if (ld || inc) begin
        chk("ld_inc_exclusive", ld & inc, 0);
        if (q.size() == 0) chk("unexpected_strobe", {ld, inc}, 0);
        else begin
          e = q.pop_front();
          chk("strobe_ld", ld, e.ld);
          chk("strobe_inc", inc, !e.ld);
          if (e.ld) last_d = e.d;
          chk("data_in", data_in, last_d);
          if (e.gap != 0) chk("strobe_gap", cyc - prev_cyc, e.gap);
          mdl = e.ld ? e.d : mdl + 8'd1;
        end
        prev_cyc = cyc;
        if (ld) ld_cyc = cyc;
      end
    end
  end
  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit chain, output int acc);
    int n, k;
    bit r;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    k = 0;
    forever begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      if (r) break;
      k++;
      if (k > 300) break;
    end
    #1 cmd_valid = 1'b0;
    acc = cyc;
    if (!r) begin
      chk("accept_timeout", r, 1);
      return;
    end
    n = (op == 2'd1 || op == 2'd2) ? 1 : op == 2'd3 ? int'(d) : 0;
    if (!chain) idle_gap = 0;
    if (n == 0) idle_gap++;
    for (int i = 0; i < n; i++) q.push_back('{ld: op == 2'd1, d: d, gap: i > 0 ? 1 : chain ? 1 + idle_gap : 0});
    if (n > 0) idle_gap = 0;
  endtask
  task automatic drain();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((q.size() != 0 || busy) && k < 3000);
    if (k >= 3000) chk("drain_timeout", q.size(), 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    mdl = 8'd0;
    last_d = 8'd0;
    idle_gap = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic reset_chk();
    @(negedge clk);
    chk("rst_ld", ld, 0);
    chk("rst_inc", inc, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
`ifdef CNTR_SEQ_SHADOW_EN
    chk("rst_exp_q", exp_q, 0);
`endif
  endtask
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = 8'd0;
    vecs = 0;
    errs = 0;
    cyc = 0;
    prev_cyc = 0;
    ld_cyc = 0;
    do_reset();
    reset_chk();
    send(2'd3, 8'd200, 0, a);
    repeat (10) @(posedge clk);
    do_reset();
    reset_chk();
    repeat (3) begin
      @(negedge clk);
      chk("burst_discarded", {ld, inc, busy}, 0);
    end
    @(posedge clk);
    #1;
    send(2'd1, 8'hA5, 0, a);
    drain();
    chk("load_latency", ld_cyc - a, 2);
    repeat (2) @(negedge clk);
`ifdef CNTR_SEQ_SHADOW_EN
    chk("exp_q_after_load", exp_q, 8'hA5);
`endif
    @(posedge clk);
    #1;
    send(2'd3, 8'd5, 0, a);
    send(2'd1, 8'h10, 1, a);
    drain();
    @(posedge clk);
    #1;
    send(2'd3, 8'd10, 0, a);
    for (int i = 0; i < 4; i++) send(2'd3, 8'd3, 1, a);
    @(negedge clk);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    @(posedge clk);
    #1;
    send(2'd2, 8'd0, 1, a);
    drain();
    @(posedge clk);
    #1;
    send(2'd1, 8'd1, 0, a);
    send(2'd0, 8'd0, 1, a);
    send(2'd2, 8'd0, 1, a);
    send(2'd3, 8'd0, 1, a);
    send(2'd2, 8'd0, 1, a);
    drain();
    @(posedge clk);
    #1;
    send(2'd1, 8'hFF, 0, a);
    send(2'd2, 8'd0, 1, a);
    drain();
    repeat (2) @(negedge clk);
`ifdef CNTR_SEQ_SHADOW_EN
    chk("exp_q_wrap", exp_q, 8'h00);
`endif
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      op = 2'($urandom_range(0, 3));
      send(op, op == 2'd3 ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255)), 0, a);
    end
    drain();
    @(negedge clk);
    chk("final_idle", {ld, inc, busy}, 0);
    chk("final_queue", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
